robo_ctrl_param: RTL

Parametrised wall-following cleaning-robot controller, the successor to the current five-state robot FSM. It adds:
- start-gated arming after reset and after a cliff or fault stop;
- a configurable debris-collection duration;
- a consecutive-turn watchdog with a latched FAULT state;
- an explicit sensor priority order, so transitions never depend on overlapping patterns.

It sits between the sensor front-end (head, left, under, barrier) and the drive/turn/collector actuators.

---
 rtl/robo_pkg.sv | 20 ++
 rtl/robo_debounce.sv | 53 +++++
 rtl/robo_ctrl_param.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/robo_pkg.sv
// Shared state encodings and turn-direction codes for the wall-following robot controller.
package robo_pkg;

    typedef logic [2:0] robo_state_t;

    localparam robo_state_t STANDBY      = 3'd0;
    localparam robo_state_t AVANCANDO    = 3'd1;
    localparam robo_state_t ROTACIONANDO = 3'd2;
    localparam robo_state_t RET_ENTULHO  = 3'd3;
    localparam robo_state_t GIROS        = 3'd4;
    localparam robo_state_t FAULT        = 3'd5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic is_turning(input robo_state_t s);
        return (s == ROTACIONANDO) || (s == GIROS);
    endfunction

endpackage

// File: rtl/robo_debounce.sv
// Per-sensor front end: 2-flop synchroniser, plus a stability filter when ROBO_DEBOUNCE_EN is defined.
module robo_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1, s2;

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

`ifdef ROBO_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          stable;

    // cnt tracks consecutive synchronised samples that disagree with the filtered value
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign q = stable;
`else
    // filter length has no meaning without the stability counter
    localparam int unsigned UNUSED_DEBOUNCE = DEBOUNCE_CYCLES;

    assign q = s2;
`endif

endmodule

// File: rtl/robo_ctrl_param.sv
// Wall-following cleaning-robot controller: arming, collection timer, turn watchdog, latched FAULT.
// Optional sensor debouncing is enabled by defining ROBO_DEBOUNCE_EN.
module robo_ctrl_param
    import robo_pkg::*;
#(
    parameter int unsigned COLLECT_CYCLES  = 4,
    parameter int unsigned TURN_LIMIT      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       head,
    input  logic       left,
    input  logic       under,
    input  logic       barrier,
    output logic       avancar,
    output logic       girar,
    output logic       girar_dir,
    output logic       recolher_entulho,
    output logic [2:0] estado,
    output logic       fault
);

    localparam int unsigned COLL_W = $clog2(COLLECT_CYCLES + 1);
    localparam int unsigned TURN_W = $clog2(TURN_LIMIT + 1);
    localparam logic [COLL_W-1:0] COLL_LOAD = COLL_W'(COLLECT_CYCLES - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_LIMIT - 1);
    localparam logic [TURN_W-1:0] TURN_MAX  = TURN_W'(TURN_LIMIT);

    logic [3:0]        sens_raw, sens_q;
    logic              under_q, head_q, left_q, barrier_q;
    robo_state_t       state, state_n, rule_state;
    logic              armed, armed_n, rule_load, use_rules;
    logic [COLL_W-1:0] coll_cnt, coll_n;
    logic [TURN_W-1:0] turn_cnt, turn_n;

    assign sens_raw = {under, head, left, barrier};

    for (genvar i = 0; i < 4; i++) begin : g_front
        robo_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .d    (sens_raw[i]),
            .q    (sens_q[i])
        );
    end

    assign {under_q, head_q, left_q, barrier_q} = sens_q;

    // Strict priority chain, so overlapping sensor patterns resolve one way only
    always_comb begin
        rule_state = AVANCANDO;
        rule_load  = 1'b0;
        if (under_q) begin
            rule_state = STANDBY;
        end else if (head_q && barrier_q) begin
            rule_state = STANDBY;
        end else if (barrier_q) begin
            rule_state = RET_ENTULHO;
            rule_load  = 1'b1;
        end else if (head_q) begin
            rule_state = left_q ? GIROS : ROTACIONANDO;
        end else if (!left_q && state == AVANCANDO) begin
            rule_state = ROTACIONANDO;
        end
        if (is_turning(rule_state) && turn_cnt == TURN_LAST) begin
            rule_state = FAULT;
        end
    end

    always_comb begin
        state_n   = state;
        coll_n    = coll_cnt;
        armed_n   = armed;
        use_rules = 1'b0;
        turn_n    = '0;
        if (is_turning(state)) begin
            turn_n = (turn_cnt == TURN_MAX) ? turn_cnt : turn_cnt + 1'b1;
        end
        if (under_q && state != FAULT) begin
            armed_n = 1'b0;
        end else if (start) begin
            armed_n = 1'b1;
        end
        case (state)
            STANDBY:                        use_rules = armed;
            AVANCANDO, ROTACIONANDO, GIROS: use_rules = 1'b1;
            RET_ENTULHO: begin
                if (coll_cnt != '0) begin
                    if (under_q) begin
                        state_n = STANDBY;
                    end else begin
                        coll_n = coll_cnt - 1'b1;
                    end
                end else begin
                    use_rules = 1'b1;
                end
            end
            FAULT: begin
                if (start) begin
                    state_n = STANDBY;
                end
            end
            default: state_n = STANDBY;
        endcase
        if (use_rules) begin
            state_n = rule_state;
            if (rule_load) begin
                coll_n = COLL_LOAD;
            end
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state    <= STANDBY;
            armed    <= 1'b0;
            coll_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_n;
            armed    <= armed_n;
            coll_cnt <= coll_n;
            turn_cnt <= turn_n;
        end
    end

    always_comb begin
        avancar          = 1'b0;
        girar            = 1'b0;
        girar_dir        = DIR_LEFT;
        recolher_entulho = 1'b0;
        fault            = 1'b0;
        case (state)
            AVANCANDO:    avancar = 1'b1;
            ROTACIONANDO: begin
                girar     = 1'b1;
                girar_dir = DIR_LEFT;
            end
            GIROS: begin
                girar     = 1'b1;
                girar_dir = DIR_RIGHT;
            end
            RET_ENTULHO:  recolher_entulho = 1'b1;
            FAULT:        fault = 1'b1;
            default:      ;
        endcase
    end

    assign estado = state;

endmodule
